normalize_ctrl: RTL
===================

// Module: normalize_ctrl
// PURPOSE
//  Multi-cycle post-add normalization sequencer for the fixed-point adder datapath.
//  Registers a 25-bit unnormalized sum (bit 24 = carry, bit 23 = hidden-one position).
//  Drives the leading-one detector FindFirstOne (N=25), shifts the mantissa and adjusts the exponent.
//  Returns a normalized fraction, exponent and status flags over a valid/ready handshake.
// PARAMETERS
//  MANT_W  25  input sum width incl. carry bit; fixed by FindFirstOne, must stay 25
//  EXP_W   8   exponent width; all-ones = overflow code, 0 = zero/flush code
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        upstream sum/exponent valid
//  in_ready   out  1        block can accept (high only in IDLE)
//  in_mant    in   25       unnormalized sum
//  in_exp     in   EXP_W    exponent associated with bit 23
//  in_sign    in   1        sign of the sum
//  out_valid  out  1        normalized result valid
//  out_ready  in   1        downstream accepts result
//  out_frac   out  23       normalized fraction, hidden bit removed
//  out_exp    out  EXP_W    adjusted exponent
//  out_sign   out  1        in_sign passed through unchanged
//  out_flags  out  3        {ovf, unf, zero}
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n low at a rising edge): next state IDLE.
//   out_valid, out_frac, out_exp, out_sign, out_flags and busy all become 0; in_ready becomes 1.
//   Reset mid-operation abandons the transaction; nothing is emitted for it.
//  FSM: IDLE -> DETECT -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1. On an edge with in_valid=1, capture in_mant, in_exp and in_sign, then go to DETECT.
//   DETECT: FindFirstOne is driven from the captured mantissa. Register index and valid. Go to SHIFT.
//   SHIFT: compute the result from the registered index, register it into the output regs, go to DONE.
//   DONE: out_valid=1. Outputs are held stable while out_ready=0.
//    On an edge with out_ready=1, go to IDLE and clear out_valid.
//  Latency: accept at edge E0; out_valid is high from edge E2.
//   No same-edge accept in DONE; minimum 4 cycles per transaction.
//  Arithmetic, with idx = registered FindFirstOne index and e = captured exponent:
//   valid=0 (sum is 0): frac=0, exp=0, zero=1.
//   idx=24: mant>>1, dropped LSB is truncated (no rounding), exp=e+1.
//    If e+1 = 2^EXP_W-1: exp=all-ones, frac=0, ovf=1.
//   idx=23: no shift, exp=e.
//   idx<23: sh=23-idx (range 1..23), mant<<sh, exp=e-sh.
//    If e<=sh: flush, exp=0, frac=0, unf=1.
//   frac is always bits [22:0] of the shifted mantissa. At most one flag is set.
//  Exponent compare uses EXP_W+1 bits; no silent wrap of exp.
//  in_exp=0 with a nonzero mantissa is not special-cased; the normal rules apply (idx=23 gives exp 0).
// TESTING
//  T1 carry: mant=25'h1800000, exp=8'h80 accepted at E0
//   -> out_valid at E2, frac=23'h400000, exp=8'h81, flags=3'b000.
//  T2 left shift: mant=25'h0000100, exp=8'h80 -> idx=8, sh=15, frac=0, exp=8'h71, flags=0.
//  T3 zero and overflow: mant=0, exp=8'h55 -> frac=0, exp=0, flags=3'b001.
//   Then mant=25'h1000000, exp=8'hFE -> exp=8'hFF, frac=0, flags=3'b100.
//  T4 underflow: mant=25'h0000001, exp=8'h10 (sh=23 >= 16) -> frac=0, exp=0, flags=3'b010.
//   sign=1 passes through to out_sign=1.
//  T5 backpressure: hold out_ready=0 for 5 cycles in DONE.
//   -> outputs constant, in_ready=0, in_valid ignored. out_ready=1 -> IDLE next edge, in_ready=1.
//  T6 reset mid-op: rst_n=0 on the edge while in SHIFT.
//   -> next cycle out_valid=0, busy=0, in_ready=1. A new transaction then completes normally.

Source files
------------

// File: rtl/normalize_ctrl.sv
// Post-add normalization sequencer: captures a 25-bit unnormalized sum, locates the
// leading one, shifts the mantissa and adjusts the exponent, returning the result over valid/ready.
module normalize_ctrl #(
  parameter int MANT_W = 25,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [22:0]       out_frac,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic [2:0]        out_flags,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DETECT = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // FindFirstOne (N=25): returns {valid, index of the most significant set bit}
  function automatic logic [5:0] find_first_one(input logic [24:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < 25; i++) begin
      if (v[i]) begin
        r = {1'b1, i[4:0]};
      end
    end
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [24:0]       mant_q;
  logic [EXP_W-1:0]  exp_q;
  logic              sign_q;
  logic [4:0]        idx_q;
  logic              ffo_vld_q;
  logic [5:0]        ffo_s;

  logic [22:0]       frac_d;
  logic [EXP_W-1:0]  exp_d;
  logic [2:0]        flags_d;
  logic [4:0]        sh_s;
  logic [24:0]       mant_shl_s;
  logic [EXP_W:0]    exp_inc_s;

  logic              out_valid_q, in_ready_q, busy_q, out_sign_q;
  logic [22:0]       out_frac_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic [2:0]        out_flags_q;

  assign ffo_s = find_first_one(mant_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DETECT; else state_d = IDLE;
      DETECT:  state_d = SHIFT;
      SHIFT:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Result arithmetic; exponent comparisons are done one bit wider so nothing wraps
  always_comb begin
    sh_s       = 5'd23 - idx_q;
    mant_shl_s = mant_q << sh_s;
    exp_inc_s  = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
    frac_d     = 23'd0;
    exp_d      = {EXP_W{1'b0}};
    flags_d    = 3'b000;
    if (!ffo_vld_q) begin
      flags_d = 3'b001;
    end else if (idx_q == 5'd24) begin
      if (exp_inc_s >= EXP_MAX) begin
        exp_d   = {EXP_W{1'b1}};
        flags_d = 3'b100;
      end else begin
        frac_d = mant_q[23:1];
        exp_d  = exp_inc_s[EXP_W-1:0];
      end
    end else if (idx_q == 5'd23) begin
      frac_d = mant_q[22:0];
      exp_d  = exp_q;
    end else begin
      if ({1'b0, exp_q} <= {{(EXP_W-4){1'b0}}, sh_s}) begin
        flags_d = 3'b010;
      end else begin
        frac_d = mant_shl_s[22:0];
        exp_d  = exp_q - {{(EXP_W-5){1'b0}}, sh_s};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mant_q      <= 25'd0;
      exp_q       <= {EXP_W{1'b0}};
      sign_q      <= 1'b0;
      idx_q       <= 5'd0;
      ffo_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_frac_q  <= 23'd0;
      out_exp_q   <= {EXP_W{1'b0}};
      out_sign_q  <= 1'b0;
      out_flags_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      if (state_q == IDLE && in_valid) begin
        mant_q <= in_mant;
        exp_q  <= in_exp;
        sign_q <= in_sign;
      end
      if (state_q == DETECT) begin
        idx_q     <= ffo_s[4:0];
        ffo_vld_q <= ffo_s[5];
      end
      if (state_q == SHIFT) begin
        out_frac_q  <= frac_d;
        out_exp_q   <= exp_d;
        out_sign_q  <= sign_q;
        out_flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_frac  = out_frac_q;
  assign out_exp   = out_exp_q;
  assign out_sign  = out_sign_q;
  assign out_flags = out_flags_q;

endmodule
